// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding and default geometry for the RAM arbiter
package ram_ctrl_pkg;
    localparam int DEF_AW = 3;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        INIT   = 2'd3
    } state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester handshakes, responses and RAM pins of the arbiter
interface ram_arbiter_if
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_data_out,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output ram_we, ram_addr, ram_data_in, busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_data_out,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  ram_we, ram_addr, ram_data_in, busy
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant selection
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic grant,
    output logic grant_any
);
    assign grant_any = valid0 | valid1;
    // A lone requester always wins; rr_ptr only breaks ties.
    assign grant     = (valid0 && valid1) ? rr_ptr : valid1;
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin sequencer for a single-port RAM
// Optional CLEAR_ON_RESET_EN: zero-fill sweep of every RAM word after reset.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input logic         clk,
    input logic         rst,
    ram_arbiter_if.slave bus
);
    state_t        state, state_nxt;
    logic          rr_ptr;
    logic          grant, grant_any, hs;
    logic          owner, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;

`ifdef CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = INIT;
    logic [AW-1:0] init_cnt;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    rr_arb2 u_rr_arb2 (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_any (grant_any)
    );

    assign hs             = (state == IDLE) && grant_any;
    assign bus.req0_ready = hs && !grant;
    assign bus.req1_ready = hs && grant;

    always_ff @(posedge clk) begin
        if (rst) state <= RST_STATE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
`ifdef CLEAR_ON_RESET_EN
            INIT:    if (init_cnt == {AW{1'b1}}) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            if (hs) begin
                owner     <= grant;
                rr_ptr    <= ~grant;
                cmd_we    <= grant ? bus.req1_we    : bus.req0_we;
                cmd_addr  <= grant ? bus.req1_addr  : bus.req0_addr;
                cmd_wdata <= grant ? bus.req1_wdata : bus.req0_wdata;
            end
            rsp0_valid <= (state == RESP) && !owner;
            rsp1_valid <= (state == RESP) && owner;
            // Sampling at the end of RESP covers both registered and combinational RAM reads.
            if (state == RESP && !cmd_we) begin
                if (owner) rsp1_rdata <= bus.ram_data_out;
                else       rsp0_rdata <= bus.ram_data_out;
            end
        end
    end

`ifdef CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst)                 init_cnt <= '0;
        else if (state == INIT)  init_cnt <= init_cnt + 1'b1;
    end

    // The sweep must not write while reset is still held.
    assign bus.ram_we      = ((state == ACCESS) && cmd_we) || ((state == INIT) && !rst);
    assign bus.ram_addr    = (state == INIT) ? init_cnt : cmd_addr;
    assign bus.ram_data_in = (state == INIT) ? '0 : cmd_wdata;
`else
    assign bus.ram_we      = (state == ACCESS) && cmd_we;
    assign bus.ram_addr    = cmd_addr;
    assign bus.ram_data_in = cmd_wdata;
`endif

    assign bus.busy       = (state != IDLE);
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp0_rdata = rsp0_rdata;
    assign bus.rsp1_rdata = rsp1_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - table-driven self-checking bench for ram_arbiter (CLEAR_ON_RESET_EN aware)
module tb_ram_arbiter;
    import ram_ctrl_pkg::*;

    localparam int AW = DEF_AW;
    localparam int DW = DEF_DW;
`ifdef CLEAR_ON_RESET_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 8x8 RAM with a registered read port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_addr];
    end

    typedef struct {
        logic          v0, v1;
        logic          we0, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          exp_owner;
        logic [DW-1:0] exp_rdata;
        logic          stale;
        logic          gap;
    } vec_t;

    vec_t          vecs [14];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            last_hs = 0;
    logic [DW-1:0] last_rdata [2];

    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic v0, v1, we0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic we1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic own, input logic [DW-1:0] rd,
                                input logic stale, gap);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.exp_owner = own; v.exp_rdata = rd; v.stale = stale; v.gap = gap;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drop_valids();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
`ifdef CLEAR_ON_RESET_EN
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("init_we",    32'(bus.ram_we), 32'd1);
            check("init_addr",  32'(bus.ram_addr), 32'(i));
            check("init_data",  32'(bus.ram_data_in), 32'd0);
            check("init_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            check("init_busy",  32'(bus.busy), 32'd1);
            if (i == 7) drop_valids();
            @(negedge clk);
        end
        #1;
        check("init_done_we",   32'(bus.ram_we), 32'd0);
        check("init_done_busy", 32'(bus.busy), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_valids();
        @(negedge clk);
        @(negedge clk);
        check("rst_we",     32'(bus.ram_we), 32'd0);
        check("rst_addr",   32'(bus.ram_addr), 32'd0);
        check("rst_din",    32'(bus.ram_data_in), 32'd0);
        check("rst_rsp0",   32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1",   32'(bus.rsp1_valid), 32'd0);
        check("rst_rdata0", 32'(bus.rsp0_rdata), 32'd0);
        check("rst_rdata1", 32'(bus.rsp1_rdata), 32'd0);
        check("rst_busy",   32'(bus.busy), 32'(FEAT));
        release_reset();
    endtask

    task automatic run_vec(input vec_t v);
        int            n;
        logic          own, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d, er;
        bus.req0_valid = v.v0; bus.req0_we = v.we0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
        bus.req1_valid = v.v1; bus.req1_we = v.we1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
        n = 0;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("ready_seen", 32'(bus.req0_ready | bus.req1_ready), 32'd1);
        check("one_ready",  32'(bus.req0_ready & bus.req1_ready), 32'd0);
        check("grant",      32'(bus.req1_ready), 32'(v.exp_owner));
        if (v.gap) check("hs_gap", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
        own = v.exp_owner;
        we  = own ? v.we1 : v.we0;
        a   = own ? v.a1  : v.a0;
        d   = own ? v.d1  : v.d0;
        @(negedge clk);
        check("acc_we",   32'(bus.ram_we), 32'(we));
        check("acc_addr", 32'(bus.ram_addr), 32'(a));
        check("acc_busy", 32'(bus.busy), 32'd1);
        check("acc_rsp",  32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
        if (we) check("acc_din", 32'(bus.ram_data_in), 32'(d));
        @(negedge clk);
        check("resp_we",   32'(bus.ram_we), 32'd0);
        check("resp_addr", 32'(bus.ram_addr), 32'(a));
        @(negedge clk);
        check("rsp0_valid", 32'(bus.rsp0_valid), 32'(!own));
        check("rsp1_valid", 32'(bus.rsp1_valid), 32'(own));
        if (!we) last_rdata[own] = (v.stale && FEAT) ? '0 : v.exp_rdata;
        er = last_rdata[own];
        check("rsp_rdata", 32'(own ? bus.rsp1_rdata : bus.rsp0_rdata), 32'(er));
    endtask

    initial begin
        rst = 1'b1;
        drop_valids();
        bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

        //            v0 v1 we0 a0 d0     we1 a1 d1     own rdata  stale gap
        vecs[0]  = mk(1, 0, 1, 0, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 8'h3C, 1, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 8'h00, 0, 1, 8'h00, 0, 8'hA5, 1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h3C, 1, 1);
        vecs[6]  = mk(1, 1, 1, 2, 8'h11, 1, 3, 8'h22, 0, 8'h00, 0, 0);
        vecs[7]  = mk(1, 1, 1, 4, 8'h33, 1, 3, 8'h22, 1, 8'h00, 0, 1);
        vecs[8]  = mk(1, 1, 1, 4, 8'h33, 0, 2, 8'h00, 0, 8'h00, 0, 1);
        vecs[9]  = mk(1, 1, 0, 3, 8'h00, 0, 2, 8'h00, 1, 8'h11, 0, 1);
        vecs[10] = mk(1, 1, 0, 3, 8'h00, 0, 4, 8'h00, 0, 8'h22, 0, 1);
        vecs[11] = mk(1, 1, 0, 3, 8'h00, 0, 4, 8'h00, 1, 8'h33, 0, 1);
        vecs[12] = mk(1, 1, 0, 4, 8'h00, 0, 3, 8'h00, 0, 8'h33, 1, 0);
        vecs[13] = mk(0, 1, 0, 4, 8'h00, 0, 3, 8'h00, 1, 8'h22, 1, 1);

        do_reset();
`ifdef CLEAR_ON_RESET_EN
        run_vec(mk(1, 0, 0, 7, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0));
`endif
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        do_reset();
        for (int i = 4; i < 6; i++) run_vec(vecs[i]);

        do_reset();
        for (int i = 6; i < 12; i++) run_vec(vecs[i]);

        // Reset lands during the ACCESS cycle of a write to address 2
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 3'd2; bus.req0_wdata = 8'h77;
        bus.req1_valid = 1'b0;
        #1;
        check("mid_ready0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        check("mid_acc_we", 32'(bus.ram_we), 32'd1);
        rst = 1'b1;
        drop_valids();
        @(negedge clk);
        check("mid_we_off", 32'(bus.ram_we), 32'd0);
        check("mid_busy",   32'(bus.busy), 32'(FEAT));
        check("mid_rsp",    32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
        release_reset();
        #1;
        check("mid_no_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
        @(negedge clk);
        check("mid_no_rsp2", 32'(bus.rsp0_valid | bus.rsp1_valid), 32'd0);
        for (int i = 12; i < 14; i++) run_vec(vecs[i]);

        drop_valids();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
